// File: rtl/shift_pkg.sv
// Mode encoding shared by the universal shift register and its users.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  function automatic logic is_shift(input logic [1:0] m);
    return (mode_e'(m) == MODE_SHR) || (mode_e'(m) == MODE_SHL);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear and a registered one-cycle wrap pulse.
module wrap_counter #(
  parameter  int MAX = 7,
  localparam int W   = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] r_cnt;
  logic         r_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (inc) begin
      if (r_cnt == W'(MAX)) begin
        r_cnt  <= '0;
        r_wrap <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_wrap <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign cnt  = r_cnt;
  assign wrap = r_wrap;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: clear, enable, parallel load, bidirectional serial shift,
// plus a shift counter that pulses done once per full word shifted.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             done
);

  logic [WIDTH-1:0] r_q;
  logic             w_cnt_inc;
  logic             w_cnt_clr;
  logic             w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      case (mode_e'(mode))
        MODE_SHR:  r_q <= {sin_r, r_q[WIDTH-1:1]};
        MODE_SHL:  r_q <= {r_q[WIDTH-2:0], sin_l};
        MODE_LOAD: r_q <= d;
        default:   r_q <= r_q;
      endcase
    end
  end

  // A load restarts the word count; clear wins over everything else.
  assign w_cnt_clr = clr | (en & (mode_e'(mode) == MODE_LOAD));
  assign w_cnt_inc = ~clr & en & is_shift(mode);

  wrap_counter #(
    .MAX (WIDTH - 1)
  ) u_wrap_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_cnt_inc),
    .clr   (w_cnt_clr),
    .cnt   (shift_cnt),
    .wrap  (w_wrap)
  );

  assign q      = r_q;
  assign sout_r = r_q[0];
  assign sout_l = r_q[WIDTH-1];
  assign done   = w_wrap;

endmodule
